block_mem_arbiter: RTL

- Shares the single command port (port 1) of block_memory among NREQ requesters: stage loader (req 0), ball 1 collision unit (req 1) and ball 2 collision unit (req 2).
- Serialises read, hit and load operations, then returns the block value to the granted requester.
- Sits between the game control logic and block_memory. The display path uses port 2 and is not touched.

---
 rtl/block_mem_arbiter_pkg.sv | 22 ++
 rtl/block_mem_arbiter_rr_priority_pick.sv | 43 ++++
 rtl/block_mem_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/block_mem_arbiter_pkg.sv
// Shared constants for the block_memory command-port arbiter:
// function codes, requester indices and the arbiter FSM encoding.
package block_mem_arbiter_pkg;

    localparam logic [1:0] FUNC_NOP  = 2'b00;
    localparam logic [1:0] FUNC_READ = 2'b01;
    localparam logic [1:0] FUNC_HIT  = 2'b10;
    localparam logic [1:0] FUNC_LOAD = 2'b11;

    localparam int REQ_STAGE = 0;
    localparam int REQ_BALL1 = 1;
    localparam int REQ_BALL2 = 2;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RESP      = 3'd4
    } state_e;

endpackage

// File: rtl/block_mem_arbiter_rr_priority_pick.sv
// Combinational picker: requester 0 always wins, the others are searched
// round-robin starting at rr_ptr_i and wrapping from NREQ-1 back to 1.
module rr_priority_pick #(
    parameter int NREQ  = 3,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic             valid_o,
    output logic [NREQ-1:0]  win_oh_o,
    output logic [IDX_W-1:0] win_idx_o
);

    logic found;
    int   start;
    int   idx;

    always_comb begin
        win_oh_o  = '0;
        win_idx_o = '0;
        found     = 1'b0;
        idx       = 0;
        start     = (rr_ptr_i == '0) ? 0 : int'(rr_ptr_i) - 1;
        if (req_i[0]) begin
            win_oh_o[0] = 1'b1;
            found       = 1'b1;
        end
        // Offsets are taken modulo the NREQ-1 ball slots so index 0 is never revisited.
        for (int k = 0; k < NREQ - 1; k++) begin
            idx = ((start + k) % (NREQ - 1)) + 1;
            for (int j = 1; j < NREQ; j++) begin
                if (!found && (j == idx) && req_i[j]) begin
                    found        = 1'b1;
                    win_oh_o[j]  = 1'b1;
                    win_idx_o    = IDX_W'(j);
                end
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/block_mem_arbiter.sv
// Serialises READ/HIT/LOAD commands from NREQ requesters onto the single
// block_memory command port and returns the block value to the winner.
module block_mem_arbiter
    import block_mem_arbiter_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int ROW_W   = 5,
    parameter int COL_W   = 5,
    parameter int BLK_W   = 4,
    parameter int BUSY_TO = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*ROW_W-1:0] req_row,
    input  logic [NREQ*COL_W-1:0] req_col,
    input  logic [NREQ*2-1:0]     req_func,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic [BLK_W-1:0]      rdata,
    output logic                  mem_enable,
    output logic [ROW_W-1:0]      mem_row,
    output logic [COL_W-1:0]      mem_col,
    output logic [1:0]            mem_func,
    input  logic [BLK_W-1:0]      mem_block,
    input  logic                  mem_busy,
    output logic [2:0]            state_dbg
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(BUSY_TO + 1);

    state_e              state_q;
    logic [NREQ-1:0]     grant_q;
    logic [NREQ-1:0]     done_q;
    logic [BLK_W-1:0]    rdata_q;
    logic                mem_enable_q;
    logic [ROW_W-1:0]    mem_row_q;
    logic [COL_W-1:0]    mem_col_q;
    logic [1:0]          mem_func_q;
    logic [IDX_W-1:0]    win_q;
    logic [IDX_W-1:0]    rr_ptr_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                pick_valid;
    logic [NREQ-1:0]     pick_oh;
    logic [IDX_W-1:0]    pick_idx;
    logic [ROW_W-1:0]    row_d;
    logic [COL_W-1:0]    col_d;
    logic [1:0]          func_d;
    logic [IDX_W-1:0]    rr_ptr_d;

    rr_priority_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i     (req),
        .rr_ptr_i  (rr_ptr_q),
        .valid_o   (pick_valid),
        .win_oh_o  (pick_oh),
        .win_idx_o (pick_idx)
    );

    always_comb begin
        row_d  = '0;
        col_d  = '0;
        func_d = FUNC_NOP;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_oh[i]) begin
                row_d  = req_row[i*ROW_W +: ROW_W];
                col_d  = req_col[i*COL_W +: COL_W];
                func_d = req_func[i*2 +: 2];
            end
        end
    end

    assign rr_ptr_d = (win_q == IDX_W'(NREQ - 1)) ? IDX_W'(1) : win_q + IDX_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            done_q       <= '0;
            rdata_q      <= '0;
            mem_enable_q <= 1'b0;
            mem_row_q    <= '0;
            mem_col_q    <= '0;
            mem_func_q   <= FUNC_NOP;
            win_q        <= '0;
            rr_ptr_q     <= IDX_W'(1);
            cnt_q        <= '0;
        end else begin
            done_q       <= '0;
            mem_enable_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pick_valid) begin
                        grant_q <= pick_oh;
                        win_q   <= pick_idx;
                        if (func_d == FUNC_NOP) begin
                            state_q <= S_RESP;
                        end else begin
                            // Strobe is raised on entry so it is high exactly during ISSUE.
                            mem_enable_q <= 1'b1;
                            mem_row_q    <= row_d;
                            mem_col_q    <= col_d;
                            mem_func_q   <= func_d;
                            state_q      <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (mem_busy) begin
                        state_q <= S_WAIT_DONE;
                    end else if (cnt_q == CNT_W'(BUSY_TO - 1)) begin
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (!mem_busy) begin
                        rdata_q <= mem_block;
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    done_q  <= grant_q;
                    grant_q <= '0;
                    if (win_q != IDX_W'(REQ_STAGE)) begin
                        rr_ptr_q <= rr_ptr_d;
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign grant      = grant_q;
    assign done       = done_q;
    assign rdata      = rdata_q;
    assign mem_enable = mem_enable_q;
    assign mem_row    = mem_row_q;
    assign mem_col    = mem_col_q;
    assign mem_func   = mem_func_q;
    assign state_dbg  = state_q;

endmodule
